step_ctrl: RTL and testbench

Run/single-step controller that sits upstream of the core on the board top level. It conditions raw push-buttons and produces the core's clock enable, so the core can free-run or execute exactly one cycle per button press. Step state is reported through ONE/DONE flags and an enabled-cycle counter. The core and mem use core_en as a synchronous enable on the system clock; no clock gating.

---
 rtl/step_ctrl.sv | 86 ++++++++
 tb/tb_step_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/step_ctrl.sv
// step_ctrl: run/single-step controller that turns raw buttons into a registered core clock enable
// Ports: clk system clock; rst synchronous active-high reset; btn_step/btn_run raw asynchronous buttons;
//   stop forces a halt while running; core_en registered enable to core/mem; flag_one high during the
//   single step; flag_done high after a step until the next step or run; running high in RUN;
//   cycle_count counts core_en cycles modulo 2^CNT_W.
module step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 125000,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_step,
  input  logic             btn_run,
  input  logic             stop,
  output logic             core_en,
  output logic             flag_one,
  output logic             flag_done,
  output logic             running,
  output logic [CNT_W-1:0] cycle_count
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [1:0] HALT = 2'd0, STEP = 2'd1, DONE = 2'd2, RUN = 2'd3;
  logic [1:0] raw, meta_q, sync_q, db_q, db_d, db_prev_q, pulse_q, mis, hit;
  logic [DW-1:0] cnt_q [2];
  logic [DW-1:0] cnt_d [2];
  logic [1:0] state_q, state_d;
  logic core_en_q, flag_one_q, flag_done_q, running_q;
  logic [CNT_W-1:0] count_q;
  logic step_p, run_p;
  assign raw = {btn_run, btn_step};
  assign mis = sync_q ^ db_q;
  assign db_d = db_q ^ hit;
  assign step_p = pulse_q[0];
  assign run_p = pulse_q[1];
  // The debounced level flips on the DEBOUNCE_CYCLES-th consecutive cycle of disagreement.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hit[i] = mis[i] && cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1);
      cnt_d[i] = (mis[i] && cnt_q[i] != DW'(DEBOUNCE_CYCLES - 1)) ? cnt_q[i] + 1'b1 : '0;
    end
  end
  // run_p is tested first in HALT/DONE so it wins over a simultaneous step_p.
  always_comb begin
    state_d = state_q;
    case (state_q)
      STEP:    state_d = DONE;
      RUN:     state_d = (run_p || stop) ? HALT : RUN;
      default: state_d = run_p ? RUN : step_p ? STEP : state_q;
    endcase
  end
  // Outputs are decoded from the next state so they are registered alongside state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q      <= '0;
      sync_q      <= '0;
      db_q        <= '0;
      db_prev_q   <= '0;
      pulse_q     <= '0;
      cnt_q       <= '{default: '0};
      state_q     <= HALT;
      core_en_q   <= 1'b0;
      flag_one_q  <= 1'b0;
      flag_done_q <= 1'b0;
      running_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      meta_q      <= raw;
      sync_q      <= meta_q;
      db_q        <= db_d;
      db_prev_q   <= db_q;
      pulse_q     <= db_q & ~db_prev_q;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      core_en_q   <= state_d == STEP || state_d == RUN;
      flag_one_q  <= state_d == STEP;
      flag_done_q <= state_d == DONE;
      running_q   <= state_d == RUN;
      count_q     <= count_q + CNT_W'(core_en_q);
    end
  end
  assign core_en = core_en_q;
  assign flag_one = flag_one_q;
  assign flag_done = flag_done_q;
  assign running = running_q;
  assign cycle_count = count_q;
endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl: self-checking bench for step_ctrl against a behavioural model
module tb_step_ctrl;
  localparam int DEB = 4, CW = 4;
  logic clk = 1'b0, rst = 1'b1, btn_step = 1'b0, btn_run = 1'b0, stop = 1'b0;
  logic core_en, flag_one, flag_done, running;
  logic [CW-1:0] cycle_count;
  int errors = 0, checks = 0;
  step_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .btn_step(btn_step), .btn_run(btn_run), .stop(stop),
    .core_en(core_en), .flag_one(flag_one), .flag_done(flag_done), .running(running),
    .cycle_count(cycle_count)
  );
  always #5 clk = ~clk;
  typedef enum int {M_HALT, M_STEP, M_DONE, M_RUN} mode_t;
  mode_t m_mode = M_HALT;
  int m_count = 0;
  bit m_s1 [2], m_s2 [2], m_db [2], m_dbo [2], m_p [2];
  int m_len [2];
  // Reference: buttons pass a 2-cycle sync delay, a level is accepted after DEB cycles of
  // sustained disagreement, a rising edge becomes a one-cycle press event, and the mode
  // machine reacts to last cycle's events. Stages are updated last-to-first.
  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_HALT;
      m_count = 0;
      for (int i = 0; i < 2; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_dbo[i] = 0; m_p[i] = 0; m_len[i] = 0;
      end
    end else begin
      if (m_mode == M_STEP || m_mode == M_RUN) m_count = (m_count + 1) % (1 << CW);
      case (m_mode)
        M_STEP:  m_mode = M_DONE;
        M_RUN:   if (m_p[1] || stop) m_mode = M_HALT;
        default: if (m_p[1]) m_mode = M_RUN; else if (m_p[0]) m_mode = M_STEP;
      endcase
      for (int i = 0; i < 2; i++) begin
        m_p[i] = m_db[i] && !m_dbo[i];
        m_dbo[i] = m_db[i];
        if (m_s2[i] != m_db[i]) begin
          m_len[i]++;
          if (m_len[i] == DEB) begin m_db[i] = !m_db[i]; m_len[i] = 0; end
        end else m_len[i] = 0;
        m_s2[i] = m_s1[i];
        m_s1[i] = (i == 1) ? btn_run : btn_step;
      end
    end
  end
  function automatic logic [7:0] dv();
    return {core_en, flag_one, flag_done, running, cycle_count};
  endfunction
  function automatic logic [7:0] ev();
    return {m_mode == M_STEP || m_mode == M_RUN, m_mode == M_STEP, m_mode == M_DONE,
            m_mode == M_RUN, CW'(m_count)};
  endfunction
  int en_n, one_n, first_en, done_in_en, run_rises, bad, bad_c;
  logic [7:0] bad_d, bad_e;
  task automatic do_reset;
    rst = 1'b1; btn_step = 1'b0; btn_run = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  // Runs n cycles with buttons high for the first step_hi/run_hi cycles, optionally pulsing stop
  // once stop_en enabled cycles have been seen; gathers observations and model disagreements.
  task automatic drive(input int n, input int step_hi, input int run_hi, input int stop_en);
    logic pr;
    en_n = 0; one_n = 0; first_en = -1; done_in_en = 0; run_rises = 0; bad = 0;
    pr = running;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (dv() !== ev()) begin
        if (bad == 0) begin bad_c = c; bad_d = dv(); bad_e = ev(); end
        bad++;
      end
      if (core_en) begin
        en_n++;
        if (first_en < 0) first_en = c;
        if (flag_done) done_in_en++;
      end
      if (flag_one) one_n++;
      if (running && !pr) run_rises++;
      pr = running;
      btn_step = c < step_hi;
      btn_run = c < run_hi;
      stop = stop_en > 0 && core_en && en_n == stop_en;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1; btn_step = 1'b0; btn_run = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (dv() !== 8'h00) begin errors++; $display("FAIL reset_idle cyc=%0d got=%b exp=00000000", c, dv()); end
      checks++;
      if (dv() !== ev()) begin errors++; $display("FAIL reset_model cyc=%0d got=%b exp=%b", c, dv(), ev()); end
    end
  endtask
  task automatic test_single_step;
    do_reset();
    for (int k = 1; k <= 2; k++) begin
      drive(30, 12, 0, 0);
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL step%0d_model cyc=%0d got=%b exp=%b", k, bad_c, bad_d, bad_e); end
      checks++;
      if (en_n !== 1) begin errors++; $display("FAIL step%0d_en_cycles got=%0d exp=1", k, en_n); end
      checks++;
      if (one_n !== 1) begin errors++; $display("FAIL step%0d_flag_one_cycles got=%0d exp=1", k, one_n); end
      checks++;
      if (first_en < 7 || first_en > 9) begin errors++; $display("FAIL step%0d_latency got=%0d exp=7..9", k, first_en); end
      checks++;
      if (done_in_en !== 0) begin errors++; $display("FAIL step%0d_done_during_step got=%0d exp=0", k, done_in_en); end
      checks++;
      if (flag_done !== 1'b1) begin errors++; $display("FAIL step%0d_flag_done got=%b exp=1", k, flag_done); end
      checks++;
      if (cycle_count !== CW'(k)) begin errors++; $display("FAIL step%0d_count got=%0d exp=%0d", k, cycle_count, k); end
    end
  endtask
  task automatic test_glitch;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(12, 3, 0, 0);
      checks++;
      if (en_n !== 0) begin errors++; $display("FAIL glitch%0d_en got=%0d exp=0", k, en_n); end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL glitch%0d_model cyc=%0d got=%b exp=%b", k, bad_c, bad_d, bad_e); end
    end
    checks++;
    if (dv() !== 8'h00) begin errors++; $display("FAIL glitch_final got=%b exp=00000000", dv()); end
  endtask
  task automatic test_run_stop;
    do_reset();
    drive(30, 0, 12, 5);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL run_model cyc=%0d got=%b exp=%b", bad_c, bad_d, bad_e); end
    checks++;
    if (run_rises !== 1) begin errors++; $display("FAIL run_entries got=%0d exp=1", run_rises); end
    checks++;
    if (first_en < 7 || first_en > 9) begin errors++; $display("FAIL run_latency got=%0d exp=7..9", first_en); end
    checks++;
    if (en_n !== 5) begin errors++; $display("FAIL run_en_cycles got=%0d exp=5", en_n); end
    checks++;
    if ({core_en, running} !== 2'b00) begin errors++; $display("FAIL run_halted got=%b exp=00", {core_en, running}); end
    checks++;
    if (cycle_count !== CW'(5)) begin errors++; $display("FAIL run_count got=%0d exp=5", cycle_count); end
  endtask
  task automatic test_priority;
    do_reset();
    drive(30, 12, 0, 0);
    checks++;
    if (flag_done !== 1'b1) begin errors++; $display("FAIL prio_setup_done got=%b exp=1", flag_done); end
    drive(30, 12, 12, 0);
    checks++;
    if (one_n !== 0) begin errors++; $display("FAIL prio_flag_one got=%0d exp=0", one_n); end
    checks++;
    if (run_rises !== 1 || running !== 1'b1) begin errors++; $display("FAIL prio_run got=%0d/%b exp=1/1", run_rises, running); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL prio_model cyc=%0d got=%b exp=%b", bad_c, bad_d, bad_e); end
    drive(30, 12, 0, 0);
    checks++;
    if (en_n !== 30 || one_n !== 0) begin errors++; $display("FAIL prio_step_in_run en=%0d one=%0d exp=30/0", en_n, one_n); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL prio_run_model cyc=%0d got=%b exp=%b", bad_c, bad_d, bad_e); end
  endtask
  task automatic test_wrap_reset;
    do_reset();
    drive(26, 0, 12, 0);
    checks++;
    if (en_n !== 18) begin errors++; $display("FAIL wrap_en_cycles got=%0d exp=18", en_n); end
    checks++;
    if (cycle_count !== CW'(1)) begin errors++; $display("FAIL wrap_count got=%0d exp=1", cycle_count); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL wrap_model cyc=%0d got=%b exp=%b", bad_c, bad_d, bad_e); end
    btn_run = 1'b1; rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (dv() !== 8'h00) begin errors++; $display("FAIL midrun_reset got=%b exp=00000000", dv()); end
    rst = 1'b0;
    drive(30, 0, 30, 0);
    checks++;
    if (run_rises !== 1 || running !== 1'b1) begin errors++; $display("FAIL held_run got=%0d/%b exp=1/1", run_rises, running); end
    checks++;
    if (first_en < 7 || first_en > 9) begin errors++; $display("FAIL held_run_latency got=%0d exp=7..9", first_en); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL held_run_model cyc=%0d got=%b exp=%b", bad_c, bad_d, bad_e); end
    drive(20, 0, 0, 0);
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL release_run got=%b exp=1", running); end
  endtask
  task automatic test_random;
    int seg [2];
    int tot_en;
    seg[0] = 0; seg[1] = 0; tot_en = 0;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      checks++;
      if (dv() !== ev()) begin errors++; $display("FAIL random cyc=%0d got=%b exp=%b", c, dv(), ev()); end
      if (core_en) tot_en++;
      for (int i = 0; i < 2; i++) begin
        seg[i]--;
        if (seg[i] <= 0) begin
          seg[i] = int'($urandom_range(1, 12));
          if (i == 0) btn_step = ~btn_step; else btn_run = ~btn_run;
        end
      end
      stop = $urandom_range(0, 15) == 0;
      rst = $urandom_range(0, 299) == 0;
    end
    rst = 1'b0;
    checks++;
    if (tot_en == 0) begin errors++; $display("FAIL random_activity got=0 exp>0"); end
  endtask
  initial begin
    test_reset();
    test_single_step();
    test_glitch();
    test_run_stop();
    test_priority();
    test_wrap_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
